// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;

  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

  typedef enum logic [2:0] {
    ST_REQ  = 3'd0,
    ST_WAIT = 3'd1,
    ST_DROP = 3'd2,
    ST_TRAP = 3'd3,
    ST_HALT = 3'd4
  } ifu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misalign;
  } ifu_entry_t;
endpackage

// File: rtl/ifu_fifo.sv
// Two-entry fetch queue with push, pop, flush and occupancy count.
module ifu_fifo
  import ifu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  ifu_entry_t       i_push_entry,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_count,
  output ifu_entry_t       o_head
);
  ifu_entry_t       r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Flush wins over push/pop; the caller never pushes in a flush cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!i_push && i_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_count = r_count;
  assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: fetch PC, single-outstanding imem handshake, 2-entry decode queue.
// Optional misaligned-redirect trap is enabled by defining IFU_MISALIGN_TRAP_EN.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc_out,
  output logic            fetch_misalign
);
  ifu_state_e       r_state;
  ifu_state_e       w_state_nxt;
  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  w_fetch_pc_nxt;
  logic [XLEN-1:0]  r_req_pc;
  logic [XLEN-1:0]  w_req_pc_nxt;
  logic [XLEN-1:0]  w_redirect_pc;
  logic             r_run;
  logic             w_grant;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;
  ifu_entry_t       w_push_entry;
  ifu_entry_t       w_head;
  logic [CNT_W-1:0] w_count;

`ifdef IFU_MISALIGN_TRAP_EN
  logic w_misalign_redir;
  assign w_redirect_pc    = redirect_pc;
  assign w_misalign_redir = (redirect_pc[1:0] != 2'b00);
`else
  assign w_redirect_pc = redirect_pc & ~XLEN'(3);
`endif

  // r_run keeps the request low while reset is held and releases it on the first edge after.
  assign imem_req  = r_run && (r_state == ST_REQ) && (w_count < CNT_W'(BUF_DEPTH));
  assign imem_addr = r_fetch_pc;
  assign w_grant   = imem_req && imem_gnt;
  assign if_valid  = (w_count != '0);
  assign w_pop     = if_valid && if_ready && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_REQ;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_run      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_pc   <= w_req_pc_nxt;
      r_run      <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_pc_nxt   = r_req_pc;
    w_push         = 1'b0;
    w_push_entry   = '0;
    w_flush        = 1'b0;
    if (redirect_valid) begin
      w_flush        = 1'b1;
      w_fetch_pc_nxt = w_redirect_pc;
      unique case (r_state)
        ST_REQ:           w_state_nxt = w_grant ? ST_DROP : ST_REQ;
        // A response arriving alongside the redirect is the stale one; drop it now.
        ST_WAIT, ST_DROP: w_state_nxt = imem_rvalid ? ST_REQ : ST_DROP;
        default:          w_state_nxt = ST_REQ;
      endcase
`ifdef IFU_MISALIGN_TRAP_EN
      if (w_misalign_redir) begin
        w_state_nxt = ST_TRAP;
      end
`endif
    end else begin
      unique case (r_state)
        ST_REQ: begin
          if (w_grant) begin
            w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
            w_req_pc_nxt   = r_fetch_pc;
            w_state_nxt    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            w_push                = 1'b1;
            w_push_entry.pc       = r_req_pc;
            w_push_entry.instr    = imem_rdata;
            w_push_entry.misalign = 1'b0;
            w_state_nxt           = ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem_rvalid) begin
            w_state_nxt = ST_REQ;
          end
        end
`ifdef IFU_MISALIGN_TRAP_EN
        ST_TRAP: begin
          w_push                = 1'b1;
          w_push_entry.pc       = r_fetch_pc;
          w_push_entry.instr    = NOP_INSTR;
          w_push_entry.misalign = 1'b1;
          w_state_nxt           = ST_HALT;
        end
        ST_HALT: w_state_nxt = ST_HALT;
`endif
        default: w_state_nxt = ST_REQ;
      endcase
    end
  end

  ifu_fifo u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (w_flush),
    .o_count      (w_count),
    .o_head       (w_head)
  );

  assign instruction    = w_head.instr;
  assign pc_out         = w_head.pc;
  assign fetch_misalign = w_head.misalign;
endmodule
